// File: rtl/tt_param_adder_acc.sv
// Registered add/sub/saturating-add/accumulate unit with a one-deep valid/ready output stage.
// The accumulator is WIDTH+GUARD bits wide; its saturation flag stays set until clear or reset.
//
// state | meaning
// EMPTY | result register holds nothing; a beat is always accepted
// FULL  | result register holds an unconsumed result (out_valid=1)
module tt_param_adder_acc #(
  parameter int WIDTH = 8,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int AW = WIDTH + GUARD;

  localparam logic [1:0] MODE_ADD    = 2'b00;
  localparam logic [1:0] MODE_SUB    = 2'b01;
  localparam logic [1:0] MODE_SATADD = 2'b10;
  localparam logic [1:0] MODE_ACC    = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             sticky_q, sticky_d;

  logic             accept;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_w;
  logic [AW-1:0]    acc_base;
  logic             sticky_base;
  logic [AW:0]      acc_sum;
  logic             acc_clip;
  logic [AW-1:0]    acc_sat;
  logic             acc_hi;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !rst && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

  // Arithmetic is computed for every mode; the beat's mode only selects what gets loaded.
  always_comb begin
    sum_w       = {1'b0, a} + {1'b0, b};
    diff_w      = a - b;
    acc_base    = clear ? '0 : acc_q;
    sticky_base = clear ? 1'b0 : sticky_q;
    acc_sum     = {1'b0, acc_base} + {{(AW + 1 - WIDTH){1'b0}}, a};
    acc_clip    = acc_sum[AW];
    acc_sat     = acc_clip ? {AW{1'b1}} : acc_sum[AW-1:0];
    acc_hi      = |acc_sat[AW-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    acc_d      = acc_base;
    sticky_d   = sticky_base;

    if (accept) begin
      state_d = FULL;
      case (mode)
        MODE_ADD: begin
          result_d   = sum_w[WIDTH-1:0];
          carry_d    = sum_w[WIDTH];
          overflow_d = 1'b0;
        end
        MODE_SUB: begin
          result_d   = diff_w;
          carry_d    = (a < b);
          overflow_d = 1'b0;
        end
        MODE_SATADD: begin
          result_d   = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
          carry_d    = 1'b0;
          overflow_d = sum_w[WIDTH];
        end
        MODE_ACC: begin
          acc_d      = acc_sat;
          sticky_d   = sticky_base | acc_clip;
          result_d   = acc_hi ? {WIDTH{1'b1}} : acc_sat[WIDTH-1:0];
          carry_d    = 1'b0;
          overflow_d = sticky_base | acc_clip | acc_hi;
        end
        default: begin
          result_d   = result_q;
          carry_d    = carry_q;
          overflow_d = overflow_q;
        end
      endcase
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      acc_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
    end
  end

endmodule

// File: tb/tb_tt_param_adder_acc.sv
// Bench for tt_param_adder_acc: directed vector table, hand-written corner sequences and
// a randomized handshake run scored against an arithmetic reference model.
module tb_tt_param_adder_acc;

  localparam int W    = 8;
  localparam int G    = 4;
  localparam int WMAX = (1 << W) - 1;
  localparam int AMAX = (1 << (W + G)) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   mode = 2'b00;
  logic         clear = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  int m_acc = 0;
  bit m_sticky = 1'b0;

  typedef struct {
    int r;
    bit c;
    bit o;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int md;
    bit clr;
    int r;
    bit c;
    bit o;
  } vec_t;

  exp_t sb[$];

  tt_param_adder_acc #(.WIDTH(W), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the model: clear always applies; the beat only if accepted.
  task automatic model_step(input bit acc_en, input int av, input int bv, input int md,
                            input bit clr, output exp_t e);
    int s;
    int n;
    if (clr) begin
      m_acc = 0;
      m_sticky = 1'b0;
    end
    e.r = 0; e.c = 1'b0; e.o = 1'b0;
    if (acc_en) begin
      case (md)
        0: begin s = av + bv; e.r = s % (WMAX + 1); e.c = (s > WMAX); end
        1: begin e.r = (av - bv + WMAX + 1) % (WMAX + 1); e.c = (av < bv); end
        2: begin s = av + bv; e.r = (s > WMAX) ? WMAX : s; e.o = (s > WMAX); end
        default: begin
          n = m_acc + av;
          if (n > AMAX) begin n = AMAX; m_sticky = 1'b1; end
          m_acc = n;
          e.r = (n > WMAX) ? WMAX : n;
          e.o = m_sticky || (n > WMAX);
        end
      endcase
    end
  endtask

  // Drive one beat with out_ready=1 at a negedge, let one posedge pass, compare at the next negedge.
  task automatic send(input int av, input int bv, input int md, input bit clr, input string nm,
                      output exp_t e);
    in_valid = 1'b1; out_ready = 1'b1;
    a = W'(av); b = W'(bv); mode = 2'(md); clear = clr;
    #1;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    model_step(1'b1, av, bv, md, clr, e);
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " result"}, 32'(result), 32'(e.r));
    chk({nm, " carry"}, 32'(carry), 32'(e.c));
    chk({nm, " overflow"}, 32'(overflow), 32'(e.o));
  endtask

  initial begin
    vec_t vt[$];
    exp_t e;
    exp_t h;
    logic [W-1:0] held;
    int beats;
    bit acc_en;
    bit exp_ir;

    vt.push_back('{200, 100, 0, 1'b0,  44, 1'b1, 1'b0});
    vt.push_back('{  3,   4, 0, 1'b0,   7, 1'b0, 1'b0});
    vt.push_back('{255,   1, 0, 1'b0,   0, 1'b1, 1'b0});
    vt.push_back('{  5,   9, 1, 1'b0, 252, 1'b1, 1'b0});
    vt.push_back('{  9,   5, 1, 1'b0,   4, 1'b0, 1'b0});
    vt.push_back('{200, 100, 2, 1'b0, 255, 1'b0, 1'b1});
    vt.push_back('{ 20,  30, 2, 1'b0,  50, 1'b0, 1'b0});
    vt.push_back('{128, 127, 2, 1'b0, 255, 1'b0, 1'b0});
    vt.push_back('{100,  77, 3, 1'b0, 100, 1'b0, 1'b0});
    vt.push_back('{100,   0, 3, 1'b0, 200, 1'b0, 1'b0});
    vt.push_back('{ 50,  50, 0, 1'b0, 100, 1'b0, 1'b0});
    vt.push_back('{100,   0, 3, 1'b0, 255, 1'b0, 1'b1});
    vt.push_back('{  7,   0, 3, 1'b1,   7, 1'b0, 1'b0});

    // Reset state
    repeat (2) @(negedge clk);
    chk("in_ready during rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset carry", 32'(carry), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Vector table: back-to-back beats, checked against the table's constants
    for (int i = 0; i < vt.size(); i++) begin
      send(vt[i].a, vt[i].b, vt[i].md, vt[i].clr, $sformatf("vec%0d", i), e);
      chk($sformatf("vec%0d tbl result", i), 32'(result), 32'(vt[i].r));
      chk($sformatf("vec%0d tbl carry", i), 32'(carry), 32'(vt[i].c));
      chk($sformatf("vec%0d tbl overflow", i), 32'(overflow), 32'(vt[i].o));
    end

    // Accumulator clamp and sticky flag
    send(255, 0, 3, 1'b1, "acc255 first", e);
    for (int i = 1; i < 17; i++) send(255, 0, 3, 1'b0, $sformatf("acc255 #%0d", i), e);
    chk("acc clamp acc_q", 32'(dut.acc_q), 32'(AMAX));
    chk("acc clamp ovf", 32'(overflow), 32'd1);
    send(1, 1, 0, 1'b0, "add after sticky", e);
    chk("add after sticky ovf", 32'(overflow), 32'd0);
    send(0, 0, 3, 1'b0, "acc0 sticky", e);
    chk("acc0 sticky ovf", 32'(overflow), 32'd1);

    // Clear alone while the output is held
    out_ready = 1'b0; clear = 1'b1;
    model_step(1'b0, 0, 0, 0, 1'b1, e);
    @(negedge clk);
    clear = 1'b0;
    chk("clear-only out_valid", 32'(out_valid), 32'd1);
    chk("clear-only result held", 32'(result), 32'd255);
    chk("clear-only ovf held", 32'(overflow), 32'd1);
    send(1, 0, 3, 1'b0, "acc1 after clear", e);
    chk("acc1 after clear tbl", 32'(result), 32'd1);
    chk("acc1 after clear ovf", 32'(overflow), 32'd0);

    // Backpressure: output held for 5 cycles with a pending beat
    send(10, 20, 0, 1'b0, "bp load", e);
    held = result;
    out_ready = 1'b0; in_valid = 1'b1; a = 8'd1; b = 8'd1; mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp result stable", 32'(result), 32'(held));
    end
    in_valid = 1'b0;
    send(1, 2, 0, 1'b0, "bp release 0", e);
    send(3, 4, 1, 1'b0, "bp release 1", e);
    send(250, 9, 2, 1'b0, "bp release 2", e);

    // Reset while FULL with acc=150
    send(150, 0, 3, 1'b1, "pre-rst acc150", e);
    out_ready = 1'b0;
    #2;
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst result", 32'(result), 32'd0);
    chk("async rst overflow", 32'(overflow), 32'd0);
    chk("async rst acc", 32'(dut.acc_q), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd0);
    m_acc = 0; m_sticky = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send(1, 0, 3, 1'b0, "post-rst acc1", e);
    chk("post-rst acc1 tbl", 32'(result), 32'd1);

    // Randomized handshake run scored against the model
    out_ready = 1'b1;
    @(negedge clk);
    sb.delete();
    beats = 0;
    for (int cyc = 0; cyc < 6000 && beats < 1000; cyc++) begin
      chk("rnd out_valid", 32'(out_valid), 32'(sb.size() != 0));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = W'($urandom_range(0, WMAX));
      b = W'($urandom_range(0, WMAX));
      mode = 2'($urandom_range(0, 3));
      clear = ($urandom_range(0, 31) == 0);
      #1;
      exp_ir = (sb.size() == 0) || out_ready;
      chk("rnd in_ready", 32'(in_ready), 32'(exp_ir));
      acc_en = in_valid && exp_ir;
      if (sb.size() != 0 && out_ready) begin
        h = sb.pop_front();
        chk("rnd result", 32'(result), 32'(h.r));
        chk("rnd carry", 32'(carry), 32'(h.c));
        chk("rnd overflow", 32'(overflow), 32'(h.o));
      end
      model_step(acc_en, int'(a), int'(b), int'(mode), clear, e);
      if (acc_en) begin
        sb.push_back(e);
        beats++;
      end
      @(negedge clk);
    end
    chk("rnd beat count", 32'(beats), 32'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
